// File: rtl/mlp_frame_driver.sv
// -----------------------------------------------------------------------------
// mlp_frame_driver
//   Initiator side of the mlp classifier interface. Serial 2-bit symbols are
//   packed into an N_ELEM-element frame, the frame is announced to the mlp core
//   with a one-cycle new_data strobe, and the classification bit returned with
//   output_ready is handed upstream on a valid/ready result channel. A watchdog
//   aborts the wait if the mlp core never answers.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   FILL   | accepting symbols into data[idx]; in_ready=1
//   ISSUE  | one cycle; new_data=1, watchdog cleared
//   WAIT   | waiting for output_ready; watchdog counts, aborts at TIMEOUT-1
//   RESULT | res_valid held with stable res_bit until res_ready
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream symbol handshake, in_sym the symbol
//   data              frame to the mlp core, data[0] is the first symbol
//   new_data          frame-start strobe to the mlp core
//   output_ready      mlp result valid, mlp_output the classification bit
//   res_valid/res_ready result handshake, res_bit the captured bit
//   timeout_err       one-cycle pulse on watchdog abort
//   frame_cnt         results handed off, wraps
// -----------------------------------------------------------------------------
module mlp_frame_driver #(
  parameter int N_ELEM  = 16,
  parameter int ELEM_W  = 2,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_sym,
  output logic [ELEM_W-1:0] data [N_ELEM],
  output logic              new_data,
  input  logic              output_ready,
  input  logic              mlp_output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_bit,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;

  logic accept;
  logic frame_done;
  logic take_res;
  logic expire;
  logic handshake;

  assign in_ready = (state == S_FILL);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    frame_done = 1'b0;
    take_res   = 1'b0;
    expire     = 1'b0;
    handshake  = 1'b0;
    case (state)
      S_FILL: begin
        accept = in_valid;
        if (in_valid && (idx == IDX_LAST)) begin
          frame_done = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // output_ready seen here belongs to a previous frame and is dropped
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the expiry cycle takes priority over the abort
        if (output_ready) begin
          take_res  = 1'b1;
          state_nxt = S_RESULT;
        end else if (wdog == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          handshake = 1'b1;
          state_nxt = S_FILL;
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      idx         <= '0;
      wdog        <= '0;
      new_data    <= 1'b0;
      res_valid   <= 1'b0;
      res_bit     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < N_ELEM; i++) begin
        data[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      new_data    <= frame_done;
      timeout_err <= expire;

      // data only moves on FILL accepts, so the frame is frozen for the mlp
      // from ISSUE until the result has been handed off
      if (accept) begin
        data[idx] <= in_sym;
        idx       <= frame_done ? '0 : idx + IDX_W'(1);
      end

      if (state == S_ISSUE) begin
        wdog <= '0;
      end else if (state == S_WAIT) begin
        wdog <= wdog + WD_W'(1);
      end

      if (take_res) begin
        res_bit   <= mlp_output;
        res_valid <= 1'b1;
      end else if (handshake) begin
        res_valid <= 1'b0;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mlp_frame_driver.sv
module tb_mlp_frame_driver;
  localparam int N  = 16;
  localparam int W  = 2;
  localparam int TO = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_sym;
  logic [W-1:0]  data [N];
  logic          new_data;
  logic          output_ready;
  logic          mlp_output;
  logic          res_valid;
  logic          res_ready;
  logic          res_bit;
  logic          timeout_err;
  logic [CW-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [W-1:0] exp_data [N];

  mlp_frame_driver #(.N_ELEM(N), .ELEM_W(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .data(data), .new_data(new_data),
    .output_ready(output_ready), .mlp_output(mlp_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_bit(res_bit),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < N; i++) chk(tag, data[i], exp_data[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; output_ready = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_new_data", new_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_bit", res_bit, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < N; i++) begin
      exp_data[i] = '0;
      chk("rst_data", data[i], 0);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Feed n symbols; with n==N the task returns on the ISSUE cycle.
  task automatic send(input int n, input bit fixed, input bit gaps);
    int acc = 0;
    logic [W-1:0] sym;
    while (acc < n) begin
      @(negedge clk);
      chk("in_ready_fill", in_ready, 1);
      chk("new_data_fill", new_data, 0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_sym   = W'($urandom);
      end else begin
        sym = fixed ? ((acc == 0) ? W'(1) : W'(0)) : W'($urandom_range(0, 3));
        in_valid = 1'b1;
        in_sym   = sym;
        exp_data[acc] = sym;
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (n == N) begin
      chk("new_data_issue", new_data, 1);
      chk("in_ready_issue", in_ready, 0);
      check_frame("data_issue");
    end
  endtask

  // The mlp core asserts output_ready for one cycle, d cycles after the
  // new_data cycle. A result is taken only if that lands inside the wait
  // window (cycles 1..TO after new_data); otherwise timeout_err shows on
  // cycle TO+1. w<0 leaves the result pending.
  task automatic mlp(input int d, input bit b, input int w);
    bit taken;
    int last;
    taken = (d >= 1) && (d <= TO);
    last  = taken ? d + 1 : TO + 1;
    output_ready = (d == 0);
    mlp_output   = (d == 0) ? b : 1'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      chk("res_valid_wait", res_valid, 32'(taken && k >= d + 1));
      chk("timeout_err", timeout_err, 32'(!taken && k == TO + 1));
      chk("in_ready_wait", in_ready, 32'(!taken && k == TO + 1));
      chk("new_data_wait", new_data, 0);
      if (taken && k == d + 1) chk("res_bit", res_bit, 32'(b));
      output_ready = (k == d) && (k < last);
      mlp_output   = (k == d) ? b : 1'($urandom);
    end
    output_ready = 1'b0;
    check_frame("data_hold");
    chk("frame_cnt_wait", frame_cnt, exp_cnt);
    if (taken && w >= 0) begin
      for (int j = 0; j < w; j++) begin
        @(negedge clk);
        chk("res_valid_hold", res_valid, 1);
        chk("res_bit_hold", res_bit, 32'(b));
        chk("in_ready_result", in_ready, 0);
        chk("frame_cnt_hold", frame_cnt, exp_cnt);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk("res_valid_done", res_valid, 0);
      chk("in_ready_done", in_ready, 1);
      chk("frame_cnt", frame_cnt, exp_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = '0; output_ready = 1'b0;
    mlp_output = 1'b0; res_ready = 1'b0;
    do_reset();

    send(N, 1'b1, 1'b0);       // sym0=01, rest 00
    mlp(7, 1'b1, 0);           // answer 7 cycles after new_data
    send(N, 1'b0, 1'b0);
    mlp(3, 1'b0, 20);          // result held 20 cycles
    send(N, 1'b0, 1'b1);
    mlp(TO + 5, 1'b1, 0);      // never answers
    send(N, 1'b0, 1'b0);
    mlp(0, 1'b1, 0);           // stale answer in ISSUE only
    send(N, 1'b0, 1'b0);
    mlp(TO, 1'b1, 1);          // answer on the expiry cycle
    send(N, 1'b0, 1'b0);
    mlp(1, 1'b1, 0);           // earliest possible answer

    send(9, 1'b0, 1'b0);       // reset mid-frame
    do_reset();
    send(N, 1'b0, 1'b0);
    mlp(2, 1'b1, 0);
    send(N, 1'b0, 1'b0);
    mlp(4, 1'b1, -1);          // reset with a result pending
    do_reset();

    for (int r = 0; r < 40; r++) begin
      send(N, 1'b0, 1'($urandom_range(0, 1)));
      mlp($urandom_range(0, TO + 1), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
